// File: rtl/ofifo_psum_pkg.sv
// Shared defaults for the MAC-array south-edge output FIFO bank and the
// column-slice packing helper used wherever per-column words share one bus.
package ofifo_psum_pkg;

    // psum_bw must track mac_tile's psum_bw.
    localparam int PSUM_BW_DEF = 16;
    localparam int COL_DEF     = 8;
    localparam int DEPTH_DEF   = 64;
    localparam int ADDR_BW_DEF = 6;

    function automatic int col_lsb(input int c, input int bw);
        return c * bw;
    endfunction

endpackage

// File: rtl/ofifo_psum_if.sv
// Handshake/data bundle between the array bottom row, the output FIFO bank
// and its downstream consumer (psum memory write path / SFP).
interface ofifo_psum_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic [col*psum_bw-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [col*psum_bw-1:0] out;
    logic                   o_valid;
    logic                   full;
    logic                   ready;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output in, wr, rd,
        input  out, o_valid, full, ready, overflow, underflow
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, full, ready, overflow, underflow
    );
endinterface

// File: rtl/ofifo_psum_fifo_col.sv
// One column FIFO: wrap-bit pointers, first-word-fall-through read port.
// rd here is an already-accepted pop; the parent qualifies it with o_valid.
module fifo_col #(
    parameter int psum_bw = 16,
    parameter int depth   = 64,
    parameter int addr_bw = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] wdata,
    input  logic               wr,
    input  logic               rd,
    output logic [psum_bw-1:0] rdata,
    output logic               empty,
    output logic               full
);
    localparam logic [addr_bw:0] PTR_ONE = {{addr_bw{1'b0}}, 1'b1};

    logic [addr_bw:0]   r_wptr;
    logic [addr_bw:0]   r_rptr;
    logic [psum_bw-1:0] r_mem [depth];
    logic               w_wr_acc;

    assign empty    = (r_wptr == r_rptr);
    assign full     = (r_wptr[addr_bw-1:0] == r_rptr[addr_bw-1:0]) &&
                      (r_wptr[addr_bw] != r_rptr[addr_bw]);
    assign w_wr_acc = wr & ~full;
    assign rdata    = r_mem[r_rptr[addr_bw-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
            if (rd)       r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage is intentionally not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wptr[addr_bw-1:0]] <= wdata;
    end

endmodule

// File: rtl/ofifo_psum.sv
// Output FIFO bank: one FIFO per array column to absorb the diagonal skew;
// a full row is released only once every column holds an entry.
module ofifo_psum
    import ofifo_psum_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = DEPTH_DEF,
    parameter int addr_bw = ADDR_BW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    ofifo_psum_if.slave  bus
);
    logic [col-1:0] w_empty;
    logic [col-1:0] w_full;
    logic           w_valid;
    logic           w_rd_acc;
    logic           r_overflow;
    logic           r_underflow;

    if (depth < 2 || depth != (1 << addr_bw)) begin : g_bad_cfg
        $error("ofifo_psum: depth must be a power of 2 >= 2 and equal 2**addr_bw");
    end

    assign w_valid  = ~|w_empty;
    assign w_rd_acc = bus.rd & w_valid;

    for (genvar c = 0; c < col; c++) begin : g_col
        fifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth),
            .addr_bw (addr_bw)
        ) u_fifo_col (
            .clk   (clk),
            .reset (reset),
            .wdata (bus.in[col_lsb(c, psum_bw) +: psum_bw]),
            .wr    (bus.wr[c]),
            .rd    (w_rd_acc),
            .rdata (bus.out[col_lsb(c, psum_bw) +: psum_bw]),
            .empty (w_empty[c]),
            .full  (w_full[c])
        );
    end

    // Both flags use pre-edge state: a write to a full column drops even if rd pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (|(bus.wr & w_full))     r_overflow  <= 1'b1;
            if (bus.rd && !w_valid)     r_underflow <= 1'b1;
        end
    end

    assign bus.o_valid   = w_valid;
    assign bus.full      = |w_full;
    assign bus.ready     = ~|w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule

// File: doc/ofifo_psum.md
Name: ofifo_psum

Overview:
- Output FIFO bank at the south edge of the MAC array. Consumes the per-column psum words that leave the bottom row of mac_tiles.
- Column results arrive diagonally skewed, so each column has its own FIFO. A full row of results is released only when every column holds at least one entry.
- Downstream, it feeds the psum memory write path and the SFP/accumulation stage through a single valid/read handshake.

Parameters:
- col, 8, number of array columns (independent FIFOs)
- psum_bw, 16, width of one psum word
- depth, 64, entries per column FIFO; must be a power of 2, minimum 2
- addr_bw, 6, log2(depth); supplied by the parent and checked by assertion

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in  in  col*psum_bw  psum words from array bottom row; column c at bits [c*psum_bw +: psum_bw]
- wr  in  col  per-column write strobe (the column's out_s valid)
- rd  in  1  pop one word from every column
- out  out  col*psum_bw  head entry of each column, same packing as in
- o_valid  out  1  every column non-empty
- full  out  1  at least one column full
- ready  out  1  no column full (~full)
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: rd seen while o_valid=0

Behaviour:
- Per-column pointers:
  - wptr and rptr are addr_bw+1 bits; the extra bit is the wrap bit.
  - empty_c = (wptr==rptr).
  - full_c = (addr bits equal, wrap bits differ).
- Reset (synchronous, when reset=1 at the edge):
  - all pointers 0, overflow=0, underflow=0.
  - Consequently o_valid=0, full=0, ready=1.
  - out is don't-care while o_valid=0; the bench must not check it.
  - Storage contents are not cleared.
  - Reset wins over any same-cycle wr/rd; a mid-stream reset discards all queued data.
- Write:
  - Column c stores in[c] at wptr_c and increments wptr_c when wr[c]=1 and full_c=0 at the edge.
  - Columns are fully independent, so any subset of wr bits may be set.
- Write to full column:
  - The word is dropped and wptr_c is unchanged.
  - overflow is set at that edge and holds until reset.
  - This holds even if rd=1 in the same cycle; full is evaluated pre-edge.
- Read:
  - Accepted when rd=1 and o_valid=1; every rptr_c increments together.
  - rd=1 with o_valid=0: no pointer moves, underflow is set (sticky until reset).
- Simultaneous write and read on the same non-full column: both take effect and the occupancy is unchanged.
- Output timing:
  - First-word-fall-through: out[c] = mem_c[rptr_c] combinationally from registered pointers.
  - o_valid, full and ready are combinational from registered pointers.
  - A word written at edge N is visible at out, and o_valid rises if all other columns are non-empty, after edge N.
  - Latency from write to observable is 1 cycle.
- Wrap-around: pointers wrap modulo 2*depth. After depth writes and depth reads the FIFO is empty again and the wrap bit has toggled.
- Width: data is stored unmodified. No sign extension, saturation or ReLU happens here; that belongs to SFP.
- There is no state machine beyond the pointers. All state is the per-column pointer pair and the two sticky flags.

Decomposition:
- Shared package holds:
  - the psum_bw default, kept consistent with mac_tile's psum_bw.
  - the col and depth defaults.
  - the column-slice packing helper, also used by the array top-level.
- Sub-module fifo_col:
  - one column FIFO with ports clk, reset, wdata, wr, rd, rdata, empty, full.
  - Instantiated col times with a generate loop.
  - The parent derives o_valid as the AND of ~empty, full as the OR of full, and the sticky flags.

Test Plan:
- Reset then idle: after reset, o_valid=0, full=0, ready=1, overflow=0, underflow=0 for 5 cycles, with wr=0 and rd=0.
- Skewed fill:
  - Stimulus: col=8; column c writes 16'h0100+c at cycle c, i.e. wr one-hot, shifting each cycle.
  - Response: o_valid stays 0 through cycle 7 and rises after the edge of cycle 7.
  - Then out = {16'h0107,...,16'h0100}, and rd pops it and drops o_valid.
- Fill to full:
  - Stimulus: depth=4; write 4 words 1,2,3,4 to all columns, then a 5th write of 9.
  - Response: full=1 and ready=0 after the 4th edge, and overflow=1 after the 5th.
  - Four reads then return 1,2,3,4 and o_valid=0.
- Underflow: rd=1 on an empty FIFO -> pointers unchanged, underflow=1, sticky until reset.
- Concurrent read/write, wrap:
  - Stimulus: depth=4; stream 10 words with wr and rd both high each cycle after a 1-word prefill.
  - Response: output order is exact (prefill, 0..8), occupancy stays 1, and the pointer wrap bit toggles without a false full or empty.
- Reset mid-operation: with 3 entries per column, assert reset for 1 cycle together with wr=all and rd=1 -> next cycle o_valid=0, full=0, overflow=0, and no write was captured.
